seg_display_scan_controller: RTL
================================

# seg_display_scan_controller

Time-multiplexes four BCD digits onto one shared BCD-to-seven-segment decoder and a common-segment, active-low-anode 4-digit display. It sits between the count/value logic and the decoder, and owns the digit scan schedule, the anti-ghosting blanking guard and the frame-synchronous update of displayed data. Digit data is double-buffered, so a value change never shows half-old/half-new digits within a frame.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot (blank + show); must be > BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must be ≥ 1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable; low forces idle with display dark.
- digits  input  16  four BCD digits; [3:0] = digit 0 (least significant) … [15:12] = digit 3.
- load  input  1  one-cycle strobe; captures `digits` into the pending buffer.
- dp_mask  input  4  decimal point per digit, bit i = digit i, active-high; sampled live, not buffered.
- bcd  output  4  BCD code to the shared decoder.
- anode  output  4  active-low digit select; at most one bit low at any time.
- dp  output  1  decimal point for the currently selected digit.
- digit_idx  output  2  index of the current slot.
- frame_done  output  1  one-cycle pulse at the end of the digit-3 show phase.

## Operation
- States: IDLE, BLANK, SHOW. Slot counter width is clog2(SCAN_DIV).
- Reset values: IDLE; anode=4'b1111, bcd=0, dp=0, digit_idx=0, frame_done=0, counter=0, display buffer=0, pending buffer=0, pending flag=0.
- IDLE, en=1: next cycle enters BLANK with digit_idx=0. This is a frame boundary.
- BLANK: anode=4'b1111; bcd and dp already present the current digit. After BLANK_CYCLES cycles, go to SHOW.
- SHOW: anode[digit_idx]=0 for SCAN_DIV−BLANK_CYCLES cycles, then go to BLANK with digit_idx+1.
  - digit_idx wraps 3→0. The 3→0 transition is a frame boundary.
  - frame_done pulses in the last SHOW cycle of digit 3.
- en=0 in any state: next cycle is IDLE with anode=4'b1111 and digit_idx=0. The pending buffer and pending flag are kept.
- Buffering:
  - load=1 writes `digits` into the pending buffer and sets the pending flag.
  - A second load before the boundary overwrites the pending value (last wins).
  - At a frame boundary, if the flag is set, pending is copied to the display buffer and the flag is cleared.
  - If load=1 in the boundary cycle itself, that cycle's `digits` bypass directly into the display buffer.
- bcd = display buffer nibble[digit_idx]. Values above 9 are passed through unchanged; the decoder defines their glyph.
- dp = dp_mask[digit_idx] during BLANK and SHOW, 0 in IDLE.

## Timing
- Registered outputs. bcd, dp and digit_idx change only on the BLANK entry edge, so the decoder has BLANK_CYCLES cycles to settle before the anode goes low.
- Digit slot = SCAN_DIV cycles exactly. Frame = 4·SCAN_DIV cycles. frame_done period = 4·SCAN_DIV.
- Load-to-visible latency is at most one frame plus one slot. It is 1 cycle when load coincides with the boundary cycle.
- Reset mid-slot: the next cycle shows reset values regardless of state. Reset wins over en and load.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - During SHOW, digit i∈{1,2,3} keeps its anode high if the display-buffer nibbles i..3 are all 0.
  - Digit 0 is always shown.
  - Slot timing, frame_done and digit_idx are unchanged.
- Not defined: every digit is shown during its SHOW phase.

## Test plan
- Bench parameters SCAN_DIV=8, BLANK_CYCLES=2.
- Reset then en=1: anode sequence per slot is 1111×2 then 1110×6, then 1111×2/1101×6, 1011, 0111 patterns. frame_done pulses every 32 cycles. No cycle has more than one anode bit low.
- load with digits=16'h1234 mid-frame: the current frame still shows the old digits. From the next boundary bcd = 4,3,2,1 in slots 0..3. Two loads (16'h1111 then 16'h5678) before the boundary: only 5678 is shown.
- load with 16'h0987 in the boundary cycle: the same frame shows 7,8,9,0.
- en dropped in SHOW of digit 2: next cycle anode=1111 and digit_idx=0. Re-enable restarts at digit 0 BLANK, and a pending load is applied at that restart.
- With LEADING_ZERO_BLANK_EN, display 16'h0050: digits 3 and 2 remain dark in SHOW, digits 1 and 0 light (5, 0). With 16'h0000 only digit 0 lights. Without the macro, all four light.
- Assert rst mid-SHOW with a pending load: all outputs return to reset values. After reset and en=1, bcd=0 in every slot, so the pending data is discarded.

Source files
------------

// File: rtl/seg_display_scan_controller.sv
// Four-digit multiplexed BCD scan controller with per-slot anti-ghosting blank and frame-synchronous
// double-buffered digit data. Optional macro: LEADING_ZERO_BLANK_EN (suppresses leading-zero digits).
module seg_display_scan_controller #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic        load,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  bcd,
    output logic [3:0]  anode,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_flag_q, pend_flag_d;
    logic [3:0]    anode_q, anode_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic          boundary;
    logic          hide;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_flag_q  <= 1'b0;
            anode_q      <= '1;
            bcd_q        <= '0;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            anode_q      <= anode_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        bcd_d       = bcd_q;
        dp_d        = dp_q;
        hide        = 1'b0;

        // Frame boundary: leaving IDLE, or the final SHOW cycle of digit 3.
        boundary = en && ((state_q == IDLE) ||
                          (state_q == SHOW && cnt_q == SLOT_LAST && idx_q == 2'd3));

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) state_d = SHOW;
                end
                SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // A load in the boundary cycle bypasses pending so it is visible in this frame.
        if (boundary) begin
            if (load) begin
                disp_d = digits;
            end else if (pend_flag_q) begin
                disp_d = pend_q;
            end
            pend_flag_d = 1'b0;
        end else if (load) begin
            pend_d      = digits;
            pend_flag_d = 1'b1;
        end

        if (state_d == IDLE) begin
            dp_d = 1'b0;
        end else if (state_d == BLANK && state_q != BLANK) begin
            bcd_d = disp_d[{idx_d, 2'b00} +: 4];
            dp_d  = dp_mask[idx_d];
        end

`ifdef LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd1:    hide = (disp_d[15:4] == 12'h000);
            2'd2:    hide = (disp_d[15:8] == 8'h00);
            2'd3:    hide = (disp_d[15:12] == 4'h0);
            default: hide = 1'b0;
        endcase
`endif

        if (state_d == SHOW && !hide) begin
            anode_d = ~(4'b0001 << idx_d);
        end else begin
            anode_d = 4'b1111;
        end

        frame_done_d = (state_d == SHOW) && (cnt_d == SLOT_LAST) && (idx_d == 2'd3);
    end

    assign bcd        = bcd_q;
    assign anode      = anode_q;
    assign dp         = dp_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule
